// File: rtl/stdp_trace_array.sv
// Dopamine-modulated STDP engine: exponentially decaying pre/post traces and a
// saturating weight file, updated by a serial one-synapse-per-clock scan.
module stdp_trace_array #(
    parameter int N_SYN    = 8,
    parameter int WEIGHT_W = 16,
    parameter int TRACE_W  = 8,
    parameter int DECAY_SH = 3,
    parameter int A_PLUS   = 4,
    parameter int A_MINUS  = 3,
    parameter int W_MIN    = 0,
    parameter int W_MAX    = 4095,
    parameter int W_INIT   = 2048,
    parameter int IDX_W    = $clog2(N_SYN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_en,
    input  logic [N_SYN-1:0]         pre_spk_i,
    input  logic                     post_spk_i,
    input  logic [7:0]               dopamine_i,
    input  logic [IDX_W-1:0]         rd_idx_i,
    output logic [WEIGHT_W-1:0]      rd_weight_o,
    output logic                     busy_o,
    output logic                     upd_valid_o,
    output logic [IDX_W-1:0]         upd_idx_o,
    output logic signed [WEIGHT_W:0] upd_dw_o,
    output logic                     dropped_o
);
    localparam logic [TRACE_W-1:0]        TRACE_MAX = '1;
    localparam logic [IDX_W-1:0]          LAST_IDX  = IDX_W'(N_SYN - 1);
    localparam logic signed [WEIGHT_W+1:0] W_MIN_X  = (WEIGHT_W+2)'(W_MIN);
    localparam logic signed [WEIGHT_W+1:0] W_MAX_X  = (WEIGHT_W+2)'(W_MAX);

    typedef enum logic {IDLE, SCAN} state_t;

    typedef struct packed {
        logic                          post;
        logic [N_SYN-1:0]              pre;
        logic [3:0]                    da;
        logic [N_SYN-1:0][TRACE_W-1:0] pre_tr;
        logic [TRACE_W-1:0]            post_tr;
    } snap_t;

    logic [N_SYN-1:0][TRACE_W-1:0] pre_tr;
    logic [TRACE_W-1:0]            post_tr;
    logic [WEIGHT_W-1:0]           weight [N_SYN];

    state_t           state;
    logic [IDX_W-1:0] idx;
    snap_t            act, pend, snap;
    logic             pend_full;
    logic             ev;
    logic             unused_da;

    function automatic logic [TRACE_W-1:0] decay(input logic [TRACE_W-1:0] tr, input logic spk);
        logic [TRACE_W-1:0] d;
        d = tr >> DECAY_SH;
        if (d == '0 && tr != '0) d = TRACE_W'(1);
        return spk ? TRACE_MAX : tr - d;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_tr  <= '0;
            post_tr <= '0;
        end else if (clk_en) begin
            for (int unsigned i = 0; i < N_SYN; i++)
                pre_tr[i] <= decay(pre_tr[i], pre_spk_i[i]);
            post_tr <= decay(post_tr, post_spk_i);
        end
    end

    // Snapshot holds the traces as they stood before this edge's decay/reload,
    // so a coincident pre/post pair contributes nothing.
    assign ev        = clk_en & (post_spk_i | (|pre_spk_i));
    assign snap      = {post_spk_i, pre_spk_i, dopamine_i[7:4], pre_tr, post_tr};
    assign unused_da = ^dopamine_i[3:0];

    logic signed [31:0]         raw, prod;
    logic signed [WEIGHT_W:0]   dw;
    logic signed [WEIGHT_W+1:0] sum;
    logic [WEIGHT_W-1:0]        cur_w, new_w;

    always_comb begin
        cur_w = weight[idx];
        raw   = '0;
        if (act.post)     raw = raw + A_PLUS * $signed(32'(act.pre_tr[idx]));
        if (act.pre[idx]) raw = raw - A_MINUS * $signed(32'(act.post_tr));
        prod = raw * $signed(32'(act.da));
        dw   = (WEIGHT_W+1)'(prod >>> TRACE_W);
        sum  = $signed({2'b00, cur_w}) + (WEIGHT_W+2)'(dw);
        if (sum < W_MIN_X)      new_w = WEIGHT_W'(W_MIN);
        else if (sum > W_MAX_X) new_w = WEIGHT_W'(W_MAX);
        else                    new_w = sum[WEIGHT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            act         <= '0;
            pend        <= '0;
            pend_full   <= 1'b0;
            busy_o      <= 1'b0;
            upd_valid_o <= 1'b0;
            upd_idx_o   <= '0;
            upd_dw_o    <= '0;
            dropped_o   <= 1'b0;
            for (int unsigned i = 0; i < N_SYN; i++)
                weight[i] <= WEIGHT_W'(W_INIT);
        end else begin
            upd_valid_o <= 1'b0;
            upd_idx_o   <= '0;
            upd_dw_o    <= '0;
            dropped_o   <= 1'b0;
            case (state)
                IDLE: begin
                    // A pending event left by a final-edge arrival starts first.
                    if (pend_full) begin
                        act    <= pend;
                        state  <= SCAN;
                        busy_o <= 1'b1;
                        idx    <= '0;
                        if (ev) pend <= snap;
                        else    pend_full <= 1'b0;
                    end else if (ev) begin
                        act    <= snap;
                        state  <= SCAN;
                        busy_o <= 1'b1;
                        idx    <= '0;
                    end
                end
                SCAN: begin
                    weight[idx] <= new_w;
                    upd_valid_o <= 1'b1;
                    upd_idx_o   <= idx;
                    upd_dw_o    <= dw;
                    if (idx == LAST_IDX) begin
                        idx <= '0;
                        if (pend_full) begin
                            act       <= pend;
                            pend_full <= 1'b0;
                            dropped_o <= ev;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                            if (ev) begin
                                pend      <= snap;
                                pend_full <= 1'b1;
                            end
                        end
                    end else begin
                        idx <= idx + 1'b1;
                        if (ev) begin
                            if (pend_full) begin
                                dropped_o <= 1'b1;
                            end else begin
                                pend      <= snap;
                                pend_full <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_weight_o <= '0;
        else     rd_weight_o <= (32'(rd_idx_i) < 32'(N_SYN)) ? weight[rd_idx_i] : '0;
    end

endmodule

// File: tb/tb_stdp_trace_array.sv
// Randomized scoreboard bench for stdp_trace_array: an event-queue reference
// model predicts per-cycle outputs and per-synapse updates for two weight inits.
module tb_stdp_trace_array;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b0;
    logic [7:0]  pre_spk = '0;
    logic        post_spk = 1'b0;
    logic [7:0]  dopamine = '0;
    logic [2:0]  rd_idx = '0;

    logic [15:0]        rd_a, rd_b;
    logic               busy_a, busy_b, valid_a, valid_b, drop_a, drop_b;
    logic [2:0]         idx_a, idx_b;
    logic signed [16:0] dw_a, dw_b;

    stdp_trace_array #(.N_SYN(8), .WEIGHT_W(16), .TRACE_W(8), .W_INIT(2048)) dut_a (
        .clk(clk), .rst(rst), .clk_en(clk_en), .pre_spk_i(pre_spk), .post_spk_i(post_spk),
        .dopamine_i(dopamine), .rd_idx_i(rd_idx), .rd_weight_o(rd_a), .busy_o(busy_a),
        .upd_valid_o(valid_a), .upd_idx_o(idx_a), .upd_dw_o(dw_a), .dropped_o(drop_a));

    stdp_trace_array #(.N_SYN(8), .WEIGHT_W(16), .TRACE_W(8), .W_INIT(4090)) dut_b (
        .clk(clk), .rst(rst), .clk_en(clk_en), .pre_spk_i(pre_spk), .post_spk_i(post_spk),
        .dopamine_i(dopamine), .rd_idx_i(rd_idx), .rd_weight_o(rd_b), .busy_o(busy_b),
        .upd_valid_o(valid_b), .upd_idx_o(idx_b), .upd_dw_o(dw_b), .dropped_o(drop_b));

    always #5 clk = ~clk;

    typedef struct packed {
        bit            post;
        bit [7:0]      pre;
        bit [3:0]      da;
        bit [7:0][7:0] pretr;
        bit [7:0]      posttr;
    } snap_t;
    typedef struct packed { bit valid; bit busy; bit drop; int rd0; int rd1; } cyc_t;
    typedef struct packed { int idx; int dw; } upd_t;

    snap_t mq[$];
    cyc_t  cq[$];
    upd_t  uq[$];
    int    mtr_pre[8];
    int    mtr_post;
    int    mw0[8];
    int    mw1[8];
    bit    mscan;
    int    mpos;
    bit    mon_en = 1'b0;
    int    total = 0;
    int    bad = 0;
    int    n_upd = 0;

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int tr_next(input int tr, input bit spk);
        int d;
        if (spk) return 255;
        d = tr / 8;
        if (d == 0 && tr > 0) d = 1;
        return tr - d;
    endfunction

    function automatic int clampw(input int v);
        return (v < 0) ? 0 : (v > 4095) ? 4095 : v;
    endfunction

    task automatic model_reset();
        mq.delete();
        mscan = 1'b0;
        mpos = 0;
        mtr_post = 0;
        for (int i = 0; i < 8; i++) begin
            mtr_pre[i] = 0;
            mw0[i] = 2048;
            mw1[i] = 4090;
        end
    endtask

    // Predicts what the coming clock edge does, given the inputs now applied.
    task automatic step();
        cyc_t  c;
        upd_t  u;
        snap_t s, a;
        bit    ev, was, drop;
        int    raw, p, dw, i;
        c.rd0 = mw0[int'(rd_idx)];
        c.rd1 = mw1[int'(rd_idx)];
        ev = clk_en && (post_spk || pre_spk != 0);
        s.post = post_spk;
        s.pre = pre_spk;
        s.da = dopamine[7:4];
        for (int k = 0; k < 8; k++) s.pretr[k] = 8'(mtr_pre[k]);
        s.posttr = 8'(mtr_post);
        was = mscan;
        drop = ev && was && mq.size() == 2;
        c.valid = was;
        if (was) begin
            a = mq[0];
            i = mpos;
            raw = 0;
            if (a.post) raw += 4 * int'(a.pretr[i]);
            if (a.pre[i]) raw -= 3 * int'(a.posttr);
            p = raw * int'(a.da);
            dw = (p >= 0) ? p / 256 : -((-p + 255) / 256);
            mw0[i] = clampw(mw0[i] + dw);
            mw1[i] = clampw(mw1[i] + dw);
            u.idx = i;
            u.dw = dw;
            uq.push_back(u);
            if (mpos == 7) begin
                mq.delete(0);
                mscan = mq.size() > 0;
                mpos = 0;
            end else begin
                mpos++;
            end
        end else if (mq.size() > 0 || ev) begin
            mscan = 1'b1;
            mpos = 0;
        end
        if (ev && !drop) mq.push_back(s);
        if (clk_en) begin
            for (int k = 0; k < 8; k++) mtr_pre[k] = tr_next(mtr_pre[k], pre_spk[k]);
            mtr_post = tr_next(mtr_post, post_spk);
        end
        c.busy = mscan;
        c.drop = drop;
        cq.push_back(c);
    endtask

    task automatic apply(input bit en, input logic [7:0] pre, input bit post,
                         input logic [7:0] da, input logic [2:0] rd);
        clk_en = en;
        pre_spk = pre;
        post_spk = post;
        dopamine = da;
        rd_idx = rd;
        if (mon_en) step();
    endtask

    task automatic tick(input bit en, input logic [7:0] pre, input bit post,
                        input logic [7:0] da, input logic [2:0] rd);
        @(negedge clk);
        apply(en, pre, post, da, rd);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b1, 8'h00, 1'b0, 8'hF0, 3'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        mon_en = 1'b0;
        rst = 1'b1;
        clk_en = 1'b0;
        pre_spk = '0;
        post_spk = 1'b0;
        #1;
        cmp("rst_busy_a", int'(busy_a), 0);
        cmp("rst_busy_b", int'(busy_b), 0);
        cmp("rst_valid", int'(valid_a), 0);
        cmp("rst_dropped", int'(drop_a), 0);
        cq.delete();
        uq.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        apply(1'b0, 8'h00, 1'b0, 8'h00, 3'd0);
    endtask

    task automatic read_check(input string name, input int idx, input int e0, input int e1);
        tick(1'b1, 8'h00, 1'b0, 8'hF0, 3'(idx));
        @(posedge clk);
        #1;
        cmp({name, "_a"}, int'(rd_a), e0);
        cmp({name, "_b"}, int'(rd_b), e1);
    endtask

    initial begin : monitor
        cyc_t c;
        upd_t u;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (cq.size() == 0) begin
                    cmp("cycle_queue_empty", 0, 1);
                end else begin
                    c = cq.pop_front();
                    cmp("busy_a", int'(busy_a), int'(c.busy));
                    cmp("busy_b", int'(busy_b), int'(c.busy));
                    cmp("dropped_a", int'(drop_a), int'(c.drop));
                    cmp("dropped_b", int'(drop_b), int'(c.drop));
                    cmp("upd_valid_a", int'(valid_a), int'(c.valid));
                    cmp("upd_valid_b", int'(valid_b), int'(c.valid));
                    cmp("rd_weight_a", int'(rd_a), c.rd0);
                    cmp("rd_weight_b", int'(rd_b), c.rd1);
                end
                if (valid_a) begin
                    n_upd++;
                    if (uq.size() == 0) begin
                        cmp("upd_queue_empty", 0, 1);
                    end else begin
                        u = uq.pop_front();
                        cmp("upd_idx_a", int'(idx_a), u.idx);
                        cmp("upd_dw_a", int'(dw_a), u.dw);
                        cmp("upd_idx_b", int'(idx_b), u.idx);
                        cmp("upd_dw_b", int'(dw_b), u.dw);
                    end
                end
            end
        end
    end

    initial begin : driver
        int         n0, ppct, qpct;
        logic [7:0] pre, da;

        do_reset();
        for (int i = 0; i < 8; i++) read_check("init_w", i, 2048, 4090);

        // LTP: pre[2] at E0, post at E2 (pending), synapse 2 gains 52 in scan 2.
        do_reset();
        tick(1'b1, 8'h04, 1'b0, 8'hF0, 3'd0);
        tick(1'b1, 8'h00, 1'b0, 8'hF0, 3'd0);
        tick(1'b1, 8'h00, 1'b1, 8'hF0, 3'd0);
        idle(16);
        read_check("ltp_w2", 2, 2100, 4095);
        read_check("ltp_w0", 0, 2048, 4090);

        // Same scenario, reset asserted after synapse 2 was written mid-scan.
        do_reset();
        tick(1'b1, 8'h04, 1'b0, 8'hF0, 3'd0);
        tick(1'b1, 8'h00, 1'b0, 8'hF0, 3'd0);
        tick(1'b1, 8'h00, 1'b1, 8'hF0, 3'd0);
        idle(9);
        @(posedge clk);
        #1;
        cmp("midscan_busy", int'(busy_a), 1);
        do_reset();
        read_check("midrst_w2", 2, 2048, 4090);

        // LTD: post at E0, pre[5] at E3.
        do_reset();
        tick(1'b1, 8'h00, 1'b1, 8'hF0, 3'd0);
        idle(2);
        tick(1'b1, 8'h20, 1'b0, 8'hF0, 3'd0);
        idle(16);
        read_check("ltd_w5", 5, 2013, 4055);

        // Coincident pre[1] and post with empty traces.
        do_reset();
        tick(1'b1, 8'h02, 1'b1, 8'hF0, 3'd0);
        idle(12);
        read_check("coinc_w1", 1, 2048, 4090);

        // Three back-to-back events: third is lost.
        do_reset();
        n0 = n_upd;
        tick(1'b1, 8'h01, 1'b0, 8'hF0, 3'd0);
        tick(1'b1, 8'h02, 1'b0, 8'hF0, 3'd0);
        tick(1'b1, 8'h04, 1'b0, 8'hF0, 3'd0);
        @(posedge clk);
        #1;
        cmp("drop_high", int'(drop_a), 1);
        idle(1);
        @(posedge clk);
        #1;
        cmp("drop_low", int'(drop_a), 0);
        idle(20);
        cmp("overflow_pulses", n_upd - n0, 16);

        // Zero dopamine nibble: scans run, weights untouched.
        do_reset();
        tick(1'b1, 8'h04, 1'b0, 8'h0F, 3'd0);
        tick(1'b1, 8'h00, 1'b1, 8'h0F, 3'd0);
        tick(1'b1, 8'h00, 1'b1, 8'h0F, 3'd0);
        for (int k = 0; k < 20; k++) tick(1'b1, 8'h00, 1'b0, 8'h0F, 3'd0);
        read_check("da0_w2", 2, 2048, 4090);

        // Randomized traffic in blocks of varying spike density.
        do_reset();
        for (int blk = 0; blk < 12; blk++) begin
            ppct = int'($urandom_range(0, 8));
            qpct = int'($urandom_range(0, 20));
            da = 8'($urandom);
            if ($urandom_range(0, 3) == 0) da[7:4] = 4'h0;
            if (blk == 6) do_reset();
            for (int k = 0; k < 200; k++) begin
                pre = '0;
                for (int b = 0; b < 8; b++)
                    if ($urandom_range(0, 99) < 32'(ppct)) pre[b] = 1'b1;
                tick($urandom_range(0, 99) < 85, pre, $urandom_range(0, 99) < 32'(qpct),
                     da, 3'($urandom_range(0, 7)));
            end
        end
        idle(30);
        @(posedge clk);
        #2;
        cmp("upd_queue_drained", uq.size(), 0);
        cmp("cycle_queue_drained", cq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
